// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction in, decoded immediate out.
// master = upstream/downstream environment, slave = the extender stage.
interface imm_extend_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered RV32I/RV64I immediate extender: one-cycle valid/ready stage with
// an output register plus a single skid entry (strict FIFO order).
// Optional feature macro: IMM_CSR_EN (decode SYSTEM opcode as CSR/I format).
module imm_extend_pipe #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    imm_extend_pipe_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_CSR_EN
    localparam logic [2:0] FMT_CSR  = 3'd6;
`endif
    localparam logic [2:0] FMT_ILL  = 3'd7;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    entry_t dec_c;
    logic   in_fire_c;
    logic   out_free_c;
    logic [31:0] instr_c;

    assign instr_c = bus.in_instr;

`ifndef IMM_CSR_EN
    // funct3 only matters for the CSR decode
    logic unused_funct3_c;
    assign unused_funct3_c = ^instr_c[14:12];
`endif

    // Decode the opcode and build the sign-extended immediate
    always_comb begin
        dec_c = '0;
        unique case (instr_c[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                dec_c.fmt = FMT_I;
                dec_c.imm = XLEN'($signed(instr_c[31:20]));
            end
            7'b0100011: begin
                dec_c.fmt = FMT_S;
                dec_c.imm = XLEN'($signed({instr_c[31:25], instr_c[11:7]}));
            end
            7'b1100011: begin
                dec_c.fmt = FMT_B;
                dec_c.imm = XLEN'($signed({instr_c[31], instr_c[7], instr_c[30:25],
                                           instr_c[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_c.fmt = FMT_U;
                dec_c.imm = XLEN'($signed({instr_c[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_c.fmt = FMT_J;
                dec_c.imm = XLEN'($signed({instr_c[31], instr_c[19:12], instr_c[20],
                                           instr_c[30:21], 1'b0}));
            end
            7'b0110011: begin
                dec_c.fmt = FMT_NONE;
            end
`ifdef IMM_CSR_EN
            7'b1110011: begin
                if (instr_c[14]) begin
                    dec_c.fmt = FMT_CSR;
                    dec_c.imm = XLEN'(instr_c[19:15]);
                end else begin
                    dec_c.fmt = FMT_I;
                    dec_c.imm = XLEN'($signed(instr_c[31:20]));
                end
            end
`endif
            default: begin
                dec_c.fmt     = FMT_ILL;
                dec_c.illegal = 1'b1;
            end
        endcase
    end

    // Output/skid steering: skid always drains first, new data bypasses to
    // the output register whenever it is empty or draining this cycle
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        in_fire_c    = bus.in_valid && in_ready_q;
        out_free_c   = !out_valid_q || bus.out_ready;

        if (skid_valid_q) begin
            if (bus.out_ready) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire_c) begin
            if (out_free_c) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec_c;
                skid_valid_d = 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers; reset discards both entries at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// directed vectors plus randomized traffic against a queue-based model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32)) b32 ();
    imm_extend_pipe_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.out_ready = out_ready;

    imm_extend_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_extend_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written as plain signed arithmetic on the fields
    function automatic void ref_decode(input logic [31:0] i, output logic [63:0] imm,
                                       output logic [2:0] fmt, output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: begin
                fmt = 3'd1;
                v = longint'(i[31:20]);
                if (i[31]) v = v - 4096;
            end
            7'h23: begin
                fmt = 3'd2;
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (i[31]) v = v - 4096;
            end
            7'h63: begin
                fmt = 3'd3;
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (i[31]) v = v - 4096;
            end
            7'h37, 7'h17: begin
                fmt = 3'd4;
                v = longint'(i[31:12]) * 4096;
                if (i[31]) v = v - 64'sh1_0000_0000;
            end
            7'h6F: begin
                fmt = 3'd5;
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (i[31]) v = v - 64'sh10_0000;
            end
            7'h33: fmt = 3'd0;
`ifdef IMM_CSR_EN
            7'h73: begin
                if (i[14]) begin
                    fmt = 3'd6;
                    v = longint'(i[19:15]);
                end else begin
                    fmt = 3'd1;
                    v = longint'(i[31:20]);
                    if (i[31]) v = v - 4096;
                end
            end
`endif
            default: begin
                fmt = 3'd7;
                ill = 1'b1;
            end
        endcase
        imm = 64'(v);
    endfunction

    // Scoreboard: the model queue holds what the stage should contain
    always @(negedge clk) begin
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        int          sz;
        logic        acc;
        if (!rst_n) begin
            model_q.delete();
        end else begin
            sz  = model_q.size();
            acc = in_valid && (sz < 2);
            check("in_ready32", 64'(b32.in_ready), 64'(sz < 2));
            check("in_ready64", 64'(b64.in_ready), 64'(sz < 2));
            check("out_valid32", 64'(b32.out_valid), 64'(sz != 0));
            check("out_valid64", 64'(b64.out_valid), 64'(sz != 0));
            if (sz != 0) begin
                ref_decode(model_q[0], e_imm, e_fmt, e_ill);
                check("imm32", 64'(b32.out_imm), {32'h0, e_imm[31:0]});
                check("imm64", b64.out_imm, e_imm);
                check("fmt32", 64'(b32.out_fmt), 64'(e_fmt));
                check("fmt64", 64'(b64.out_fmt), 64'(e_fmt));
                check("ill32", 64'(b32.out_illegal), 64'(e_ill));
                check("ill64", 64'(b64.out_illegal), 64'(e_ill));
                if (out_ready) void'(model_q.pop_front());
            end
            if (acc) model_q.push_back(in_instr);
        end
    end

    // Single transfer with out_ready=1, checked one cycle after accept
    task automatic directed(input string tag, input logic [31:0] instr,
                            input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        in_valid  = 1'b1;
        in_instr  = instr;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
        check({tag, "_imm"}, 64'(b32.out_imm), 64'(imm));
        check({tag, "_fmt"}, 64'(b32.out_fmt), 64'(fmt));
        check({tag, "_ill"}, 64'(b32.out_illegal), 64'(ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [13];
        logic [31:0] r;
        int          idx;
        ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F, 7'h0B};
        r   = $urandom();
        idx = int'($urandom_range(0, 13));
        if (idx < 13) r[6:0] = ops[idx];
        return r;
    endfunction

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_imm", 64'(b32.out_imm), 64'd0);
        check("rst_fmt", 64'(b32.out_fmt), 64'd0);
        check("rst_ill", 64'(b32.out_illegal), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);

        // Directed format vectors
        directed("i_neg",  32'hA549A303, 32'hFFFFFA54, 3'd1, 1'b0);
        directed("i_zero", 32'h0004A303, 32'h00000000, 3'd1, 1'b0);
        directed("s",      32'hFE512E23, 32'hFFFFFFFC, 3'd2, 1'b0);
        directed("b",      32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0);
        directed("j",      32'h001000EF, 32'h00000800, 3'd5, 1'b0);
        directed("u",      32'h123450B7, 32'h12345000, 3'd4, 1'b0);
        directed("illegal", 32'h0000007F, 32'h0, 3'd7, 1'b1);
        directed("r_add",  32'h00B50533, 32'h0, 3'd0, 1'b0);
`ifdef IMM_CSR_EN
        directed("csrrwi", 32'h3402D073, 32'h5, 3'd6, 1'b0);
`else
        directed("csrrwi", 32'h3402D073, 32'h0, 3'd7, 1'b1);
`endif
        directed("u_neg",  32'h800000B7, 32'h80000000, 3'd4, 1'b0);
        check("u_neg_imm64", b64.out_imm, 64'hFFFFFFFF80000000);

        // Backpressure: A, B accepted, C held until the stage drains
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100013;
        @(posedge clk); #1;
        in_instr  = 32'h00200013;
        @(posedge clk); #1;
        check("bp_in_ready_b", 64'(b32.in_ready), 64'd0);
        check("bp_out_a", 64'(b32.out_imm), 64'd1);
        in_instr  = 32'h00300013;
        @(posedge clk); #1;
        check("bp_hold_c", 64'(b32.in_ready), 64'd0);
        check("bp_hold_a", 64'(b32.out_imm), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_out_b", 64'(b32.out_imm), 64'd2);
        check("bp_ready_again", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_out_c", 64'(b32.out_imm), 64'd3);
        check("bp_c_valid", 64'(b32.out_valid), 64'd1);
        @(posedge clk); #1;
        check("bp_drained", 64'(b32.out_valid), 64'd0);

        // Reset with output and skid both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00700013;
        @(posedge clk); #1;
        in_instr  = 32'h00800013;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_full", 64'(b32.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid32", 64'(b32.out_valid), 64'd0);
        check("mid_rst_valid64", 64'(b64.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(b32.in_ready), 64'd1);
        directed("post_rst", 32'h00500013, 32'h5, 3'd1, 1'b0);

        // Randomized traffic checked by the scoreboard
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            @(posedge clk); #1;
        end

        // Drain with a bounded wait
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10 && model_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(model_q.size()), 64'd0);
        @(negedge clk); #1;
        check("drain_out_valid", 64'(b32.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Registered, handshaked immediate generator for all RV32I/RV64I immediate formats (I, S, B, U, J). Takes a full 32-bit instruction and sign-extends its immediate to XLEN. Reports the decoded format and an illegal-opcode flag. Sits between fetch/decode and the execute operand muxes in the pipelined core, replacing the combinational extender with a 1-cycle valid/ready stage backed by a 2-entry skid buffer.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; all sign extension is to XLEN bits.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; registered (= skid buffer empty)
in_instr  in  32  full instruction word
out_valid  out  1  out_imm/out_fmt/out_illegal valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  0 NONE(R-type), 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 ILLEGAL
out_illegal  out  1  opcode not recognised

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, skid empty, in_ready=1 on the first clk edge after release.
- Decode on opcode in_instr[6:0]:
  - I: 0000011, 0010011, 1100111, 0001111; imm = sext(instr[31:20]). Shift-immediates need no special case.
  - S: 0100011; sext({instr[31:25], instr[11:7]}).
  - B: 1100011; sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 0110111, 0010111; sext({instr[31:12], 12'b0}), sign-extended when XLEN=64.
  - J: 1101111; sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 0110011; imm=0, fmt=0.
  - Anything else: imm=0, fmt=7, illegal=1.
- Handshake: a transfer occurs when valid&&ready on either side. Data must be held stable while out_valid=1 && out_ready=0.
- Latency and throughput: 1 cycle; an instruction accepted at edge N appears at out_* after edge N. Sustains 1 instruction/cycle while out_ready=1.
- Storage: output register plus one skid register. An accepted input loads the output register if it is empty or draining this cycle, otherwise it loads the skid register. When the output register drains and the skid register is full, the skid entry moves to the output register.
- in_ready = skid empty. With out_ready held 0, exactly 2 instructions are accepted before in_ready drops.
- Ordering: strict FIFO. The skid entry is always delivered before any newer entry.
- Simultaneous events: with the skid full and out_ready=1 in the same cycle, skid→out happens and the input is not accepted (in_ready was 0). With the output full, skid empty, out_ready=1 and in_valid=1, the new entry goes directly to the output register.
- Reset mid-operation: both entries are discarded immediately and out_valid drops asynchronously.
- in_instr is ignored when in_valid=0. No X propagation: decoded fields are registered only on accept.

Optional Feature:
Macro IMM_CSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) gives fmt=6 and imm = zero-extended instr[19:15] (uimm). Opcode 1110011 with funct3[2]=0 gives fmt=1 and imm = sext(instr[31:20]) (CSR address/ECALL field).
- Undefined: opcode 1110011 gives fmt=7 and illegal=1; fmt code 6 is never produced.

Test Plan:
1. XLEN=32, out_ready=1: in_instr=0xA549A303 (I) -> out_imm=0xFFFFFA54, fmt=1, illegal=0 one cycle after accept. 0x00000000 load-form 0x0004A303 -> 0x00000000.
2. S/B/J: 0xFE512E23 -> 0xFFFFFFFC fmt=2; 0xFE000CE3 -> 0xFFFFFFF8 fmt=3; 0x001000EF -> 0x00000800 fmt=5.
3. U and width: XLEN=32, 0x123450B7 -> 0x12345000 fmt=4. XLEN=64, 0x800000B7 -> 0xFFFFFFFF80000000.
4. Illegal/R: 0x0000007F -> imm=0, fmt=7, illegal=1. 0x00B50533 (add) -> imm=0, fmt=0, illegal=0. With IMM_CSR_EN, 0x3402D073 (csrrwi uimm=5) -> imm=0x5, fmt=6; without it -> fmt=7.
5. Backpressure: out_ready=0, present I-types A, B, C back-to-back -> A and B accepted, in_ready=0 on the cycle after B, C held. Raise out_ready -> A, B, C emerge in order, one per cycle, none lost or duplicated.
6. Reset mid-operation: output and skid both full, assert rst_n=0 between edges -> out_valid=0 immediately. After release, in_ready=1 and the first new instruction emerges with 1-cycle latency.
